// File: rtl/param_sp_ram.sv
// param_sp_ram: single-port RAM with post-reset INIT_VAL sweep and parity option (SP_RAM_PARITY_EN).
// Latency: 1 cycle for reads and writes; busy is held for DEPTH edges after reset release.
// Backpressure: none per access; requests are dropped while busy=1.
module param_sp_ram #(
  parameter int                 DATA_W   = 4,
  parameter int                 ADDR_W   = 3,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0,
  parameter int                 RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              busy,
  output logic              perr
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef SP_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {INIT, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rword;
  logic              acc;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  function automatic logic [MEM_W-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef SP_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (&cnt) state_nxt = READY;
      end
      default: ;
    endcase
  end

  // busy comes straight from the state flop, so it has no input path
  assign busy  = (state == INIT);
  assign acc   = (state == READY) && en;
  assign we    = busy || (acc && wr);
  assign waddr = busy ? cnt : addr;
  assign wdata = busy ? INIT_VAL : x;
  assign rword = mem[addr];

  // array is deliberately left out of reset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= enc(wdata);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= acc;
      if (acc) y <= (wr && RDW_MODE == 1) ? x : rword[DATA_W-1:0];
    end
  end

`ifdef SP_RAM_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perr <= 1'b0;
    else      perr <= acc && !wr && (rword[DATA_W] != ^rword[DATA_W-1:0]);
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_param_sp_ram.sv
// Bench for param_sp_ram: read-first and write-first instances driven in lockstep against an array model.
module tb_param_sp_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, wr;
  logic [2:0] addr;
  logic [3:0] x;
  logic [3:0] y0, y1;
  logic       yv0, yv1, busy0, busy1, perr0, perr1;

  always #5 clk = ~clk;

  param_sp_ram dut0 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .x(x),
    .y(y0), .y_valid(yv0), .busy(busy0), .perr(perr0)
  );

  param_sp_ram #(.RDW_MODE(1), .INIT_VAL(4'h6)) dut1 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .x(x),
    .y(y1), .y_valid(yv1), .busy(busy1), .perr(perr1)
  );

  int         vectors;
  int         miscompares;
  logic [3:0] m0 [8];
  logic [3:0] m1 [8];
  logic [3:0] ey0, ey1;
  logic       ev;
  logic       pexp;
  int         sweep_left;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".y0"},    {4'h0, y0}, {4'h0, ey0});
    chk({tag, ".y1"},    {4'h0, y1}, {4'h0, ey1});
    chk({tag, ".vld0"},  {7'h0, yv0}, {7'h0, ev});
    chk({tag, ".vld1"},  {7'h0, yv1}, {7'h0, ev});
    chk({tag, ".busy0"}, {7'h0, busy0}, {7'h0, sweep_left > 0});
    chk({tag, ".busy1"}, {7'h0, busy1}, {7'h0, sweep_left > 0});
    chk({tag, ".perr0"}, {7'h0, perr0}, {7'h0, pexp});
    chk({tag, ".perr1"}, {7'h0, perr1}, 8'h0);
  endtask

  // One clock: drive request, advance the model, then check after the edge.
  task automatic cyc(input string tag, input logic e, input logic w,
                     input logic [2:0] a, input logic [3:0] d);
    en = e; wr = w; addr = a; x = d;
    if (sweep_left > 0) begin
      sweep_left--;
      ev = 1'b0;
    end else if (e) begin
      ev  = 1'b1;
      ey0 = m0[a];
      ey1 = w ? d : m1[a];
      if (w) begin
        m0[a] = d;
        m1[a] = d;
      end
    end else begin
      ev = 1'b0;
    end
    if (!ev) pexp = 1'b0;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    ey0 = 4'h0; ey1 = 4'h0; ev = 1'b0; pexp = 1'b0;
    sweep_left = 8;
    #1;
    chk_all({tag, ".inrst"});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m0[i] = 4'h0;
      m1[i] = 4'h6;
    end
    #1;
    chk_all({tag, ".rel"});
  endtask

  logic [3:0] wtab [8];

  initial begin
    vectors = 0; miscompares = 0;
    en = 1'b0; wr = 1'b0; addr = 3'd0; x = 4'h0;
    wtab[0] = 4'b0111; wtab[1] = 4'b1110; wtab[2] = 4'b0010; wtab[3] = 4'b1100;
    wtab[4] = 4'b0011; wtab[5] = 4'b1010; wtab[6] = 4'b0111; wtab[7] = 4'b0101;

    do_reset("rst1");
    // writes hammered at address 5 during the sweep must be dropped
    repeat (8) cyc("busywr", 1'b1, 1'b1, 3'd5, 4'hF);
    cyc("rd5", 1'b0 == 1'b0, 1'b0, 3'd5, 4'h0);
    for (int i = 0; i < 8; i++) cyc("initrd", 1'b1, 1'b0, 3'(i), 4'h0);

    for (int i = 0; i < 8; i++) cyc("wrsweep", 1'b1, 1'b1, 3'(i), wtab[i]);
    for (int i = 0; i < 8; i++) cyc("rdsweep", 1'b1, 1'b0, 3'(i), 4'h0);

    cyc("rdw.pre", 1'b1, 1'b1, 3'd3, 4'b1100);
    cyc("rdw.wr",  1'b1, 1'b1, 3'd3, 4'b0001);
    cyc("rdw.rd",  1'b1, 1'b0, 3'd3, 4'h0);

    cyc("hold.rd", 1'b1, 1'b0, 3'd1, 4'h0);
    cyc("hold.i0", 1'b0, 1'b1, 3'd1, 4'h9);
    cyc("hold.i1", 1'b0, 1'b0, 3'd4, 4'h3);

    for (int i = 0; i < 300; i++)
      cyc("rand", $urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 4'($urandom));

    // reset in the middle of an access, then again mid-sweep (edge 4)
    cyc("pre.rst", 1'b1, 1'b1, 3'd6, 4'hB);
    do_reset("rst2");
    repeat (4) cyc("sweep4", 1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom));
    do_reset("rst3");
    repeat (8) cyc("sweep8", 1'b1, 1'($urandom), 3'($urandom), 4'($urandom));
    for (int i = 0; i < 8; i++) cyc("postrd", 1'b1, 1'b0, 3'(i), 4'h0);

`ifdef SP_RAM_PARITY_EN
    cyc("par.wr", 1'b1, 1'b1, 3'd2, 4'h5);
    dut0.mem[2] = dut0.mem[2] ^ 5'b00100;
    m0[2] = 4'h1;
    pexp = 1'b1;
    cyc("par.bad", 1'b1, 1'b0, 3'd2, 4'h0);
    pexp = 1'b0;
    cyc("par.rewr", 1'b1, 1'b1, 3'd2, 4'h5);
    cyc("par.ok",   1'b1, 1'b0, 3'd2, 4'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
